avalon_wait_ram: RTL and testbench

//  Word-organised RAM acting as an Avalon-MM slave to top_level_cpu. Each access inserts a programmable number of wait states.

---
 rtl/avalon_wait_ram.sv | 111 +++++++++++
 tb/tb_avalon_wait_ram.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_wait_ram.sv
// Word-organised Avalon-MM slave RAM with programmable wait states, byte-enabled
// writes and a synchronous preload port that takes priority over the bus.
module avalon_wait_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic              waitrequest,
  output logic [31:0]       readdata,
  output logic              bus_error,
  input  logic              inst_input,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       instruction
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_readdata;
  logic        r_bus_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] w_bus_idx;
  logic [ADDR_W-3:0] w_pre_idx;
  logic              w_req_one;
  logic              w_req_any;
  logic              w_commit;
  logic              w_unused;

  // Byte-offset bits and aliasing upper bits are intentionally ignored.
  assign w_unused  = ^{address[31:ADDR_W], address[1:0], inst_addr[1:0]};

  assign w_bus_idx = address[ADDR_W-1:2];
  assign w_pre_idx = inst_addr[ADDR_W-1:2];
  assign w_req_one = read ^ write;
  assign w_req_any = read | write;

  // Stall in WAIT, in IDLE on a fresh single request, and whenever preload competes with the bus.
  assign waitrequest = (r_state == StWait)
                     | ((r_state == StIdle) & w_req_one)
                     | (inst_input & w_req_any);

  // A bus write lands on the edge closing ACK, unless preload or reset claims that edge.
  assign w_commit = (r_state == StAck) & write & ~read & ~inst_input & ~reset;

  assign readdata  = r_readdata;
  assign bus_error = r_bus_error;

  // Access FSM: counts wait states, captures read data, latches the sticky bus error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_readdata  <= 32'd0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (read && write) begin
            r_bus_error <= 1'b1;
          end else if (!inst_input && w_req_one) begin
            r_state <= StWait;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        StWait: begin
          if (!w_req_any) begin
            r_state <= StIdle;
          end else if (inst_input) begin
            r_state <= StWait;
          end else if (r_cnt == 4'd0) begin
            r_state <= StAck;
            if (read) begin
              r_readdata <= r_mem[w_bus_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StAck: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Memory array: full-word preload wins over a lane-masked bus write; never cleared.
  always_ff @(posedge clk) begin
    if (inst_input) begin
      r_mem[w_pre_idx] <= instruction;
    end else if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          r_mem[w_bus_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Scoreboard bench for avalon_wait_ram: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_avalon_wait_ram;

  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;
  logic        inst_input;
  logic [9:0]  inst_addr;
  logic [31:0] instruction;

  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  avalon_wait_ram #(
    .DEPTH_WORDS(256),
    .ADDR_W     (10),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .byteenable (byteenable),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .bus_error  (bus_error),
    .inst_input (inst_input),
    .inst_addr  (inst_addr),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read ACK is the only cycle with read alone high and no stall.
  always @(negedge clk) begin
    if (read && !write && !waitrequest && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_ack", 32'd1, 32'd0);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    inst_input  = 1'b1;
    inst_addr   = a;
    instruction = d;
    @(posedge clk); #1;
    inst_input  = 1'b0;
    model[a[9:2]] = d;
  endtask

  // Issue a read; optionally hold inst_input for 'stall' cycles once the access is pending.
  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input int stall,
                          input logic [31:0] pre_data, input string name);
    int waits = 0;
    bit acked = 0;
    exp_q.push_back(exp);
    address = a;
    read    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!waitrequest) begin
        acked = 1;
        break;
      end
      waits++;
      @(posedge clk); #1;
      if (c < stall) begin
        inst_input  = 1'b1;
        inst_addr   = a[9:0];
        instruction = pre_data;
      end else begin
        inst_input  = 1'b0;
      end
    end
    if (!acked) begin
      check({name, "_ack_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    check({name, "_wait_cycles"}, 32'(waits), 32'(WC + 1 + stall));
    @(posedge clk); #1;
    read       = 1'b0;
    inst_input = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input string name);
    int waits = 0;
    bit acked = 0;
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!waitrequest) begin
        acked = 1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    if (!acked) check({name, "_ack_timeout"}, 32'd0, 32'd1);
    check({name, "_wait_cycles"}, 32'(waits), 32'(WC + 1));
    @(posedge clk); #1;
    write = 1'b0;
    if (acked) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hi;
    logic [7:0]  idx;
    logic [31:0] a;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    byteenable = '0; inst_input = 1'b0; inst_addr = '0; instruction = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_waitrequest", 32'(waitrequest), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    check("reset_bus_error", 32'(bus_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Give every word a defined value.
    for (int w = 0; w < 256; w++) preload(10'(w * 4), $urandom);

    // Preloaded program words, read with wait states.
    preload(10'h004, 32'h24020010);
    preload(10'h008, 32'h2403FFFB);
    bus_read(32'h0000_0004, 32'h24020010, 0, 32'd0, "t1_read");

    // Byte-lane merge.
    preload(10'h010, 32'h11223344);
    bus_write(32'h0000_0010, 32'hAABBCCDD, 4'b0101, "t2_write");
    bus_read(32'h0000_0010, 32'h11BB33DD, 0, 32'd0, "t2_read");

    // Aliasing of upper address bits.
    bus_read(32'hBFC0_0008, 32'h2403FFFB, 0, 32'd0, "t3_alias");

    // Empty byteenable is a no-op write.
    bus_write(32'h0000_0010, 32'h55667788, 4'b0000, "be0_write");
    bus_read(32'h0000_0010, 32'h11BB33DD, 0, 32'd0, "be0_read");

    // Simultaneous read and write.
    address = 32'h0000_0004; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    @(negedge clk);
    check("t4_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check("t4_bus_error_set", 32'(bus_error), 32'd1);
    @(posedge clk); #1;
    bus_read(32'h0000_0004, 32'h24020010, 0, 32'd0, "t4_mem_unchanged");
    check("t4_bus_error_sticky", 32'(bus_error), 32'd1);

    // Preload stalls a pending read and supplies its data.
    model[3] = 32'hCAFEF00D;
    bus_read(32'h0000_000C, 32'hCAFEF00D, 4, 32'hCAFEF00D, "t6_stall_read");

    // Reset during WAIT of a write: nothing commits.
    preload(10'h020, 32'h0BAD_F00D);
    address = 32'h0000_0020; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
    @(negedge clk);
    check("t5_idle_wait", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; write = 1'b0;
    @(negedge clk);
    check("t5_waitrequest", 32'(waitrequest), 32'd0);
    check("t5_readdata", readdata, 32'd0);
    check("t5_bus_error_cleared", 32'(bus_error), 32'd0);
    @(posedge clk); #1;
    bus_read(32'h0000_0020, 32'h0BAD_F00D, 0, 32'd0, "t5_read_old");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 60; k++) begin
      hi  = $urandom;
      idx = 8'($urandom_range(0, 255));
      a   = {hi[31:10], idx, hi[1:0]};
      case ($urandom_range(0, 2))
        0:       bus_read(a, model[idx], 0, 32'd0, "rand_read");
        1:       bus_write(a, $urandom, 4'($urandom), "rand_write");
        default: preload(a[9:0], $urandom);
      endcase
    end
    for (int w = 0; w < 8; w++) begin
      idx = 8'($urandom_range(0, 255));
      bus_read({24'd0, idx, 2'b00}, model[idx], 0, 32'd0, "final_read");
    end

    repeat (2) @(posedge clk);
    #1;
    check("bus_error_stays_clear", 32'(bus_error), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
